// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between a read
// requester and a write requester; read data returns two cycles after rd_gnt.
module sram_arbiter #(
    parameter int ADR  = 8,
    parameter int DAT  = 8,
    parameter int DPTH = 8
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic           rd_req,
    input  logic [ADR-1:0] rd_addr,
    output logic           rd_gnt,
    output logic           rd_valid,
    output logic [DAT-1:0] rd_data,
    output logic           rd_err,
    input  logic           wr_req,
    input  logic [ADR-1:0] wr_addr,
    input  logic [DAT-1:0] wr_data,
    output logic           wr_gnt,
    output logic           wr_err,
    output logic           sram_cs,
    output logic           sram_we,
    output logic           sram_rd,
    output logic [ADR-1:0] sram_addr,
    output logic [DAT-1:0] sram_din,
    input  logic [DAT-1:0] sram_dout
);

    localparam logic [ADR:0] LIMIT = (ADR+1)'(DPTH);

    function automatic logic in_range(input logic [ADR-1:0] addr);
        return {1'b0, addr} < LIMIT;
    endfunction

    logic ptr_wr;    // 1: write wins the next contended cycle
    logic rd_elig, wr_elig, rd_win, wr_win, rd_ok, wr_ok;
    logic vld_p1, err_p1, vld_p2, err_p2;

    // A requester granted this cycle is treated as consumed at the coming edge.
    always_comb begin
        rd_elig = rd_req & ~rd_gnt;
        wr_elig = wr_req & ~wr_gnt;
        rd_win  = rd_elig & (~wr_elig | ~ptr_wr);
        wr_win  = wr_elig & ~rd_win;
        rd_ok   = in_range(rd_addr);
        wr_ok   = in_range(wr_addr);
    end

    // Stage p1: grant and SRAM command
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ptr_wr    <= 1'b0;
            rd_gnt    <= 1'b0;
            wr_gnt    <= 1'b0;
            wr_err    <= 1'b0;
            sram_cs   <= 1'b0;
            sram_we   <= 1'b0;
            sram_rd   <= 1'b0;
            sram_addr <= '0;
            sram_din  <= '0;
            vld_p1    <= 1'b0;
            err_p1    <= 1'b0;
        end else begin
            if (rd_elig && wr_elig)
                ptr_wr <= rd_win;
            rd_gnt  <= rd_win;
            wr_gnt  <= wr_win;
            wr_err  <= wr_win & ~wr_ok;
            sram_rd <= rd_win & rd_ok;
            sram_we <= wr_win & wr_ok;
            sram_cs <= (rd_win & rd_ok) | (wr_win & wr_ok);
            if (rd_win && rd_ok) begin
                sram_addr <= rd_addr;
            end else if (wr_win && wr_ok) begin
                sram_addr <= wr_addr;
                sram_din  <= wr_data;
            end
            vld_p1 <= rd_win;
            err_p1 <= rd_win & ~rd_ok;
        end
    end

    // Stage p2: SRAM latches the read; stage p3: capture sram_dout as rd_data
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            vld_p2   <= 1'b0;
            err_p2   <= 1'b0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            rd_data  <= '0;
        end else begin
            vld_p2   <= vld_p1;
            err_p2   <= err_p1;
            rd_valid <= vld_p2;
            rd_err   <= vld_p2 & err_p2;
            if (vld_p2)
                rd_data <= err_p2 ? '0 : sram_dout;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model, reference model with a read-data
// scoreboard, and directed plus randomized request traffic.
module tb_sram_arbiter;

    localparam int ADR  = 8;
    localparam int DAT  = 8;
    localparam int DPTH = 8;
    localparam int AW   = $clog2(DPTH);

    logic           Clk = 1'b0;
    logic           Rst_n = 1'b1;
    logic           rd_req = 1'b0;
    logic [ADR-1:0] rd_addr = '0;
    logic           rd_gnt, rd_valid, rd_err;
    logic [DAT-1:0] rd_data;
    logic           wr_req = 1'b0;
    logic [ADR-1:0] wr_addr = '0;
    logic [DAT-1:0] wr_data = '0;
    logic           wr_gnt, wr_err;
    logic           sram_cs, sram_we, sram_rd;
    logic [ADR-1:0] sram_addr;
    logic [DAT-1:0] sram_din;
    logic [DAT-1:0] sram_dout = '0;

    int compared = 0;
    int failed   = 0;

    always #5 Clk = ~Clk;

    sram_arbiter #(.ADR(ADR), .DAT(DAT), .DPTH(DPTH)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_gnt(wr_gnt), .wr_err(wr_err),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_rd(sram_rd),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // syncRAM: write and registered read on the rising edge
    logic [DAT-1:0] mem [DPTH] = '{default: '0};
    always @(posedge Clk) begin
        if (sram_cs && sram_we && int'(sram_addr) < DPTH)
            mem[sram_addr[AW-1:0]] <= sram_din;
        if (sram_cs && sram_rd && int'(sram_addr) < DPTH)
            sram_dout <= mem[sram_addr[AW-1:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: decides the winner of each edge from the arbitration
    // rules and keeps a shadow memory updated in grant order.
    typedef struct {
        int             due;
        logic           err;
        logic [DAT-1:0] data;
    } rd_exp_t;

    rd_exp_t        rq[$];
    rd_exp_t        ent;
    logic [DAT-1:0] shadow [DPTH] = '{default: '0};
    int             mcyc = 0;
    bit             pref_wr, m_re, m_we, m_gr, m_gw, m_rok, m_wok;
    logic           e_rd_gnt, e_wr_gnt, e_wr_err, e_cs, e_rd, e_we;
    logic [ADR-1:0] e_addr;
    logic [DAT-1:0] e_din;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rq.delete();
            pref_wr  = 1'b0;
            e_rd_gnt = 1'b0; e_wr_gnt = 1'b0; e_wr_err = 1'b0;
            e_cs = 1'b0; e_rd = 1'b0; e_we = 1'b0;
            e_addr = '0; e_din = '0;
        end else begin
            mcyc++;
            m_re  = rd_req && !e_rd_gnt;
            m_we  = wr_req && !e_wr_gnt;
            m_rok = int'(rd_addr) < DPTH;
            m_wok = int'(wr_addr) < DPTH;
            if (m_re && m_we) begin
                m_gw    = pref_wr;
                m_gr    = !pref_wr;
                pref_wr = m_gr;
            end else begin
                m_gr = m_re;
                m_gw = m_we;
            end
            e_rd_gnt = m_gr;
            e_wr_gnt = m_gw;
            e_wr_err = m_gw && !m_wok;
            e_rd     = m_gr && m_rok;
            e_we     = m_gw && m_wok;
            e_cs     = e_rd || e_we;
            if (m_gr) begin
                ent.due  = mcyc + 2;
                ent.err  = !m_rok;
                ent.data = m_rok ? shadow[rd_addr[AW-1:0]] : '0;
                rq.push_back(ent);
                if (m_rok) e_addr = rd_addr;
            end
            if (m_gw && m_wok) begin
                e_addr = wr_addr;
                e_din  = wr_data;
                shadow[wr_addr[AW-1:0]] = wr_data;
            end
        end
    end

    // Monitor: compares every output on the falling edge
    logic exp_v;
    always @(negedge Clk) begin
        chk("rd_gnt", rd_gnt, e_rd_gnt);
        chk("wr_gnt", wr_gnt, e_wr_gnt);
        chk("wr_err", wr_err, e_wr_err);
        chk("sram_cs", sram_cs, e_cs);
        chk("sram_rd", sram_rd, e_rd);
        chk("sram_we", sram_we, e_we);
        chk("sram_addr", sram_addr, e_addr);
        chk("sram_din", sram_din, e_din);
        chk("we_rd_exclusive", sram_we & sram_rd, 0);
        chk("gnt_exclusive", rd_gnt & wr_gnt, 0);
        while (rq.size() > 0 && rq[0].due < mcyc) void'(rq.pop_front());
        exp_v = rq.size() > 0 && rq[0].due == mcyc;
        chk("rd_valid", rd_valid, exp_v);
        if (exp_v) begin
            if (rd_valid) begin
                chk("rd_data", rd_data, rq[0].data);
                chk("rd_err", rd_err, rq[0].err);
            end
            void'(rq.pop_front());
        end
    end

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Raise the selected requests and hold each until its grant is seen
    task automatic xfer(input bit dr, input logic [ADR-1:0] ra,
                        input bit dw, input logic [ADR-1:0] wa, input logic [DAT-1:0] wd);
        int n = 0;
        rd_req = dr; rd_addr = ra;
        wr_req = dw; wr_addr = wa; wr_data = wd;
        while ((rd_req || wr_req) && n < 20) begin
            step();
            n++;
            if (rd_gnt) rd_req = 1'b0;
            if (wr_gnt) wr_req = 1'b0;
        end
        chk("xfer_grant_timeout", {30'd0, rd_req, wr_req}, 0);
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    int rd_cnt, wr_cnt;

    initial begin
        #1 Rst_n = 1'b0;
        rd_req = 1'b1; rd_addr = 8'd3;
        wr_req = 1'b1; wr_addr = 8'd4; wr_data = 8'h77;
        idle(3);
        wr_req = 1'b0;
        Rst_n  = 1'b1;
        xfer(1, 8'd3, 0, 8'd0, 8'h00);
        idle(3);

        xfer(0, 8'd0, 1, 8'd2, 8'hA5);
        xfer(1, 8'd2, 0, 8'd0, 8'h00);
        idle(4);

        // Continuous contention from reset: grants must alternate
        Rst_n = 1'b0;
        step();
        rd_req = 1'b1; rd_addr = 8'd1;
        wr_req = 1'b1; wr_addr = 8'd4; wr_data = 8'h3C;
        Rst_n = 1'b1;
        rd_cnt = 0; wr_cnt = 0;
        repeat (12) begin
            step();
            rd_cnt += int'(rd_gnt);
            wr_cnt += int'(wr_gnt);
        end
        rd_req = 1'b0; wr_req = 1'b0;
        chk("contention_rd_grants", rd_cnt, 6);
        chk("contention_wr_grants", wr_cnt, 6);
        idle(4);

        // Same-address ordering in both pointer states
        xfer(0, 8'd0, 1, 8'd5, 8'h11);
        xfer(1, 8'd0, 1, 8'd6, 8'h44);
        xfer(1, 8'd1, 1, 8'd7, 8'h55);
        xfer(1, 8'd5, 1, 8'd5, 8'h22);
        idle(3);
        xfer(0, 8'd0, 1, 8'd5, 8'h11);
        xfer(1, 8'd5, 1, 8'd5, 8'h33);
        idle(4);

        // Out of range accesses
        xfer(1, 8'd9, 0, 8'd0, 8'h00);
        xfer(0, 8'd0, 1, 8'd8, 8'hEE);
        idle(4);

        // Reset the cycle after rd_gnt: that read must never complete
        xfer(1, 8'd5, 0, 8'd0, 8'h00);
        step();
        Rst_n = 1'b0;
        idle(2);
        Rst_n = 1'b1;
        idle(4);
        xfer(1, 8'd5, 0, 8'd0, 8'h00);
        idle(4);

        // Randomized traffic, including out-of-range addresses
        for (int i = 0; i < 600; i++) begin
            step();
            if (rd_gnt || !rd_req) begin
                rd_req  = ($urandom_range(0, 2) != 0);
                rd_addr = ADR'($urandom_range(0, 11));
            end
            if (wr_gnt || !wr_req) begin
                wr_req  = ($urandom_range(0, 2) != 0);
                wr_addr = ADR'($urandom_range(0, 11));
                wr_data = DAT'($urandom);
            end
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        idle(6);

        chk("pending_reads_left", rq.size(), 0);
        for (int a = 0; a < DPTH; a++)
            chk("sram_contents", mem[a], shadow[a]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares one single-port synchronous SRAM (`syncRAM`, CS/WE/RD control, registered read port) between a read requester (trie lookup path) and a write requester (table update path). Round-robin arbitration, one SRAM access per cycle, req/gnt handshake per requester, read data returned with a fixed latency. Sits directly in front of the SRAM instance; all SRAM control pins are driven only by this block.

## Interface

Parameters:
- `ADR`, 8: address width.
- `DAT`, 8: data width.
- `DPTH`, 8: number of SRAM words; legal addresses are 0..DPTH-1.

Ports:
- `Clk`  in  1  clock, rising edge.
- `Rst_n`  in  1  reset, asynchronous, active-low.
- `rd_req`  in  1  read request; held with `rd_addr` stable until `rd_gnt` seen.
- `rd_addr`  in  ADR  read address.
- `rd_gnt`  out  1  one-cycle pulse: read request accepted.
- `rd_valid`  out  1  one-cycle pulse: `rd_data` valid.
- `rd_data`  out  DAT  read result.
- `rd_err`  out  1  with `rd_valid`: address was out of range, `rd_data`=0.
- `wr_req`  in  1  write request; held with `wr_addr`/`wr_data` stable until `wr_gnt` seen.
- `wr_addr`  in  ADR  write address.
- `wr_data`  in  DAT  write data.
- `wr_gnt`  out  1  one-cycle pulse: write accepted.
- `wr_err`  out  1  with `wr_gnt`: address out of range, write dropped.
- `sram_cs`, `sram_we`, `sram_rd`  out  1 each  SRAM CS/WE/RD.
- `sram_addr`  out  ADR  SRAM Addr.
- `sram_din`  out  DAT  SRAM dataIn.
- `sram_dout`  in  DAT  SRAM dataOut.

## Operation

- All outputs registered. Reset values: every output 0; round-robin pointer = read-preferred; read pipeline empty.
- Eligibility at each edge: `rd_req` eligible iff `rd_gnt`=0 in the current cycle; `wr_req` likewise with `wr_gnt`. A requester whose grant is high this cycle is ignored (its req is treated as consumed), so a requester can be granted at most every other cycle.
- Arbitration at edge: one eligible -> it wins. Both eligible -> pointer winner; pointer then flips to the loser. Pointer changes only on a contended grant.
- Grant issue (registered at the same edge): winner's gnt=1; if address < DPTH: `sram_cs`=1, `sram_rd`=1 (read) or `sram_we`=1 (write), `sram_addr`, `sram_din` (write data; holds previous value on reads). If address >= DPTH: gnt=1 with err flag, `sram_cs`/`sram_rd`/`sram_we`=0.
- No grant: `sram_cs`=`sram_we`=`sram_rd`=0; addr/din hold.
- Invariant: `sram_we` and `sram_rd` never both 1; at most one of `rd_gnt`/`wr_gnt` per cycle.
- Read pipeline: 2-stage valid/err shift register tracking granted reads; stage 2 captures `sram_dout` (or 0 if err) into `rd_data`.
- Ordering: SRAM accesses execute in grant order; write granted before a read to the same address is visible to that read; read granted first returns old data.

## Timing

- Request sampled at edge E0 -> gnt and SRAM command high in cycle C1 (after E0).
- SRAM latches command at E1; `sram_dout` valid in C2.
- `rd_valid`/`rd_data`/`rd_err` high in C3 (captured at E2). Read latency req-sample to data: 3 edges; gnt to `rd_valid`: 2 cycles.
- Write commits at E1 (end of gnt cycle).
- Peak throughput: 1 access/cycle when both requesters are active (alternating); single requester: 1 access per 2 cycles.
- Reset asserted mid-operation: outputs to 0 immediately (async); in-flight reads discarded, no `rd_valid` after reset release; in-flight write may or may not commit in the SRAM. First grant possible at first edge after `Rst_n` rises.

## Test plan

- Reset: drive requests during `Rst_n`=0 -> all outputs 0, no grants; release -> first `rd_req` at addr 3 granted next cycle with `sram_cs`=1, `sram_rd`=1, `sram_addr`=3.
- Write then read: write 0xA5 to addr 2, then read addr 2 -> `wr_gnt` C1, `rd_gnt` C3, `rd_valid` C5 with `rd_data`=0xA5, `rd_err`=0.
- Contention: both reqs held continuously from reset, addrs 1 (rd) and 4 (wr) -> grants alternate rd, wr, rd, wr each cycle; never both; `sram_we`&`sram_rd` never 1.
- Same-address ordering: addr 5 holds 0x11; read and write (0x22) to addr 5 raised together after a read-won-last contention -> write first, read returns 0x22; reversed pointer -> read returns 0x11.
- Out of range (DPTH=8): read addr 9 -> `rd_gnt`, `sram_cs`=0, `rd_valid` with `rd_err`=1, `rd_data`=0; write addr 8 -> `wr_gnt` + `wr_err`, SRAM unchanged.
- Reset mid-read: assert `Rst_n`=0 the cycle after `rd_gnt` -> no `rd_valid` ever emitted for that read; post-reset read of same address completes normally.
